// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer.
// Contents: request size codes, RAM access-mode codes, FSM state type and a
// helper that flags illegal or misaligned requests.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [2:0] RAM_CTRL_WORD = 3'b000;
  localparam logic [2:0] RAM_CTRL_HALF = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // True when the request cannot be executed: illegal size, or an address
  // not aligned to the access size.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Combinational lane logic for the load/store sequencer.
// Ports:
//   size_i    request size code
//   signed_i  sign-extend loads
//   odd_i     byte address bit 0 (1 = low byte lane [7:0], big-endian)
//   rdata_i   RAM read data (word, or halfword in [15:0])
//   wbyte_i   byte to merge for a byte store
//   load_o    aligned and extended load result
//   merged_o  halfword with wbyte_i merged into the addressed lane
module mau_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic        odd_i,
  input  logic [31:0] rdata_i,
  input  logic [7:0]  wbyte_i,
  output logic [31:0] load_o,
  output logic [15:0] merged_o
);

  logic [7:0] byte_lane;

  // Even byte address lives in the upper half of the halfword.
  assign byte_lane = odd_i ? rdata_i[7:0] : rdata_i[15:8];

  always_comb begin
    load_o = '0;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_o = {{16{signed_i & rdata_i[15]}}, rdata_i[15:0]};
      SZ_WORD: load_o = rdata_i;
      default: load_o = '0;
    endcase
  end

  always_comb begin
    merged_o = odd_i ? {rdata_i[15:8], wbyte_i} : {wbyte_i, rdata_i[7:0]};
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU memory stage and the halfword RAM.
// Accepts one byte/half/word load or store, drives the RAM address, mode and
// write-enable sequence, and returns aligned, extended load data. Byte stores
// are done as a halfword read-modify-write.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we/req_size/req_signed      store flag, size code, load extension
//   req_addr/req_wdata              byte address, right-justified store data
//   resp_valid/resp_err/resp_rdata  one-cycle completion, error, load data
//   ram_addr/ram_ctrl/ram_din/ram_we  RAM request side (all registered)
//   ram_dout                        RAM read data, one cycle after address
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [2:0]        ram_ctrl,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  state_e            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              odd_q;
  logic [7:0]        wbyte_q;
  logic [ADDR_W-2:0] haddr_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [ADDR_W-2:0] ram_addr_q;
  logic [2:0]        ram_ctrl_q;
  logic [31:0]       ram_din_q;
  logic              ram_we_q;

  logic              req_bad;
  logic [ADDR_W-2:0] req_haddr;
  logic [31:0]       lane_load;
  logic [15:0]       lane_merged;

  assign req_bad   = req_illegal(req_size, req_addr[1:0]);
  // Word accesses always start on the even halfword.
  assign req_haddr = (req_size == SZ_WORD) ? {req_addr[ADDR_W-1:2], 1'b0}
                                           : req_addr[ADDR_W-1:1];

  mau_lane u_lane (
    .size_i   (size_q),
    .signed_i (signed_q),
    .odd_i    (odd_q),
    .rdata_i  (ram_dout),
    .wbyte_i  (wbyte_q),
    .load_o   (lane_load),
    .merged_o (lane_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      odd_q        <= 1'b0;
      wbyte_q      <= '0;
      haddr_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_addr_q   <= '0;
      ram_ctrl_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
    end else begin
      // RAM outputs are only non-zero during ISSUE and WRITE.
      resp_valid_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_ctrl_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            signed_q    <= req_signed;
            odd_q       <= req_addr[0];
            wbyte_q     <= req_wdata[7:0];
            haddr_q     <= req_haddr;
            req_ready_q <= 1'b0;
            if (req_bad) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q    <= ISSUE;
              ram_addr_q <= req_haddr;
              ram_ctrl_q <= (req_size == SZ_WORD) ? RAM_CTRL_WORD : RAM_CTRL_HALF;
              // Byte stores read first; only word/half stores write directly.
              ram_we_q   <= req_we && (req_size != SZ_BYTE);
              if (req_we) begin
                ram_din_q <= (req_size == SZ_WORD) ? req_wdata : {16'h0000, req_wdata[15:0]};
              end
            end
          end
        end
        ISSUE: begin
          if (we_q && (size_q != SZ_BYTE)) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (we_q) begin
            state_q    <= WRITE;
            ram_addr_q <= haddr_q;
            ram_ctrl_q <= RAM_CTRL_HALF;
            ram_din_q  <= {16'h0000, lane_merged};
            ram_we_q   <= 1'b1;
          end else begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= lane_load;
          end
        end
        WRITE: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_ctrl   = ram_ctrl_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;

endmodule
